uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : types and constants shared by the UART transmitter and receiver
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } uart_tx_state_t;

   localparam int UART_PARITY_EVEN = 0;
   localparam int UART_PARITY_ODD  = 1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx : baud-tick driven asynchronous serial transmitter, one frame in flight
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
)(
   input  logic                 clkin,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 busy
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic       PAR_INV   = (PARITY_ODD == UART_PARITY_ODD);

   uart_tx_state_t       state_q,    state_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [2:0]           bit_cnt_q,  bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 parity_q,   parity_d;
   logic                 txd_q,      txd_d;
   logic                 ready_q,    ready_d;
   logic                 busy_q,     busy_d;

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         txd_q      <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         txd_q      <= txd_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   // txd_d is the level of the state being entered, so the line changes
   // on the same edge that samples the tick.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      txd_d      = txd_q;

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (tx_valid && ready_q) begin
               shift_d  = tx_data;
               parity_d = (^tx_data) ^ PAR_INV;
               state_d  = WAIT;
            end
         end

         WAIT: begin
            if (baud_tick) begin
               state_d = START;
               txd_d   = 1'b0;
            end
         end

         START: begin
            if (baud_tick) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
               txd_d     = shift_q[0];
            end
         end

         DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                     txd_d   = parity_q;
                  end else begin
                     state_d    = STOP;
                     stop_cnt_d = 1'b0;
                     txd_d      = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  txd_d     = shift_q[1];
               end
            end
         end

         PARITY: begin
            if (baud_tick) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
               txd_d      = 1'b1;
            end
         end

         STOP: begin
            txd_d = 1'b1;
            if (baud_tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   assign tx_ready = ready_q;
   assign txd      = txd_q;
   assign busy     = busy_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx : directed frame checks on 8N1, 8E1, 8O1 and 5N2 transmitters
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int TICK = 217;

   logic       clk;
   logic       rst_n;
   logic       baud_tick;
   int         tick_phase;
   logic [3:0] valid;
   logic [7:0] data [4];
   logic [3:0] txd_w;
   logic [3:0] ready_w;
   logic [3:0] busy_w;

   int n_vec  = 0;
   int n_miss = 0;

   // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2
   uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clkin(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[0]),
      .tx_valid(valid[0]), .tx_ready(ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clkin(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[1]),
      .tx_valid(valid[1]), .tx_ready(ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
      .clkin(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[2]),
      .tx_valid(valid[2]), .tx_ready(ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));
   uart_tx #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
      .clkin(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data[3][4:0]),
      .tx_valid(valid[3]), .tx_ready(ready_w[3]), .txd(txd_w[3]), .busy(busy_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      baud_tick  = 1'b0;
      tick_phase = 0;
      forever begin
         @(posedge clk);
         #1;
         tick_phase = (tick_phase == TICK - 1) ? 0 : tick_phase + 1;
         baud_tick  = (tick_phase == TICK - 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int k, input logic [7:0] d, input bit hold);
      int n;
      n = 0;
      valid[k] = 1'b1;
      data[k]  = d;
      while (ready_w[k] !== 1'b1 && n < 4 * TICK) begin
         @(posedge clk); #2; n++;
      end
      @(posedge clk); #2;
      data[k] = ~d;
      if (!hold) valid[k] = 1'b0;
   endtask

   task automatic wait_fall(input int k, output int lat);
      lat = 0;
      while (txd_w[k] !== 1'b0 && lat < 2 * TICK + 4) begin
         @(posedge clk); #2; lat++;
      end
   endtask

   // Called two time units after the accepting edge.
   task automatic capture(input int k, input int len, input logic [11:0] exp,
                          input string tag, output int lat);
      logic [11:0] obs;
      logic        lvl;
      int          glitches;
      int          early;
      wait_fall(k, lat);
      check({tag, ":lat_ok"}, 32'(lat >= 1 && lat <= TICK), 32'd1);
      obs      = '0;
      glitches = 0;
      early    = 0;
      for (int i = 0; i < len; i++) begin
         lvl    = txd_w[k];
         obs[i] = lvl;
         if (ready_w[k] !== 1'b0 || busy_w[k] !== 1'b1) early++;
         for (int c = 1; c < TICK; c++) begin
            @(posedge clk); #2;
            if (txd_w[k] !== lvl) glitches++;
            if (ready_w[k] !== 1'b0 || busy_w[k] !== 1'b1) early++;
         end
         @(posedge clk); #2;
      end
      check({tag, ":frame"},    32'(obs), 32'(exp));
      check({tag, ":glitch"},   glitches, 0);
      check({tag, ":busy_run"}, early, 0);
      check({tag, ":txd_end"},  32'(txd_w[k]), 32'd1);
      check({tag, ":rdy_end"},  32'(ready_w[k]), 32'd1);
      check({tag, ":busy_end"}, 32'(busy_w[k]), 32'd0);
   endtask

   initial begin
      int lat;
      int bad;
      int n;
      rst_n = 1'b0;
      valid = '0;
      for (int k = 0; k < 4; k++) data[k] = 8'h00;

      // reset held with a word offered: nothing may start
      repeat (2) @(posedge clk);
      #2;
      valid[0] = 1'b1;
      data[0]  = 8'h55;
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #2;
         if (txd_w !== 4'hF || ready_w !== 4'hF || busy_w !== 4'h0) bad++;
      end
      check("rst_hold",  bad, 0);
      check("rst_txd",   32'(txd_w[0]), 32'd1);
      check("rst_ready", 32'(ready_w[0]), 32'd1);
      check("rst_busy",  32'(busy_w[0]), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;
      data[0]  = 8'hAA;
      valid[0] = 1'b0;
      capture(0, 10, 12'h2AA, "8n1_55", lat);

      // accept coincides with a tick, then a back-to-back second word
      n = 0;
      while (baud_tick !== 1'b1 && n < 2 * TICK) begin
         @(posedge clk); #2; n++;
      end
      valid[0] = 1'b1;
      data[0]  = 8'h12;
      @(posedge clk); #2;
      check("acc_ready_lo", 32'(ready_w[0]), 32'd0);
      data[0] = 8'h34;
      capture(0, 10, 12'h224, "b2b_12", lat);
      check("tick_in_accept_lat", lat, TICK);
      @(posedge clk); #2;
      check("b2b_accept", 32'(ready_w[0]), 32'd0);
      valid[0] = 1'b0;
      data[0]  = 8'hC3;
      capture(0, 10, 12'h268, "b2b_34", lat);
      check("b2b_gap", lat, TICK - 1);

      // parity variants
      send(1, 8'hA5, 1'b0);
      capture(1, 11, 12'h54A, "8e1_a5", lat);
      send(1, 8'h01, 1'b0);
      capture(1, 11, 12'h602, "8e1_01", lat);
      send(2, 8'hA5, 1'b0);
      capture(2, 11, 12'h74A, "8o1_a5", lat);

      // 5 data bits, 2 stop bits
      send(3, 8'h1B, 1'b0);
      capture(3, 8, 12'h0F6, "5n2_1b", lat);

      // reset pulse in the middle of data bit 3
      send(0, 8'h00, 1'b0);
      wait_fall(0, lat);
      repeat (4 * TICK + 100) @(posedge clk);
      #2;
      check("mid_pre_txd", 32'(txd_w[0]), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_txd",   32'(txd_w[0]), 32'd1);
      check("mid_rst_ready", 32'(ready_w[0]), 32'd1);
      check("mid_rst_busy",  32'(busy_w[0]), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 2 * TICK + 50; c++) begin
         @(posedge clk); #2;
         if (txd_w[0] !== 1'b1 || ready_w[0] !== 1'b1) bad++;
      end
      check("mid_quiet", bad, 0);
      send(0, 8'hF0, 1'b0);
      capture(0, 10, 12'h3E0, "post_rst_f0", lat);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_uart_tx
`default_nettype wire
